// File: rtl/arb_fifo_if.sv
// Handshake bundle between the pixel arbiter (write side), the FIFO and the
// processing master (read side). The FIFO uses the slave view.
interface arb_fifo_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
);
    logic                     slvx_data_valid;
    logic [1:0]               slvx_mode;
    logic [7:0]               slvx_proc_val;
    logic [DW-1:0]            slvx_data;
    logic                     fifo_full;
    logic                     fifo_afull;
    logic                     fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     mstr_valid;
    logic                     mstr_ready;
    logic [1:0]               mstr_mode;
    logic [7:0]               mstr_proc_val;
    logic [DW-1:0]            mstr_data;
    logic                     ovf_err;
    logic                     clr_err;

    modport slave (
        input  slvx_data_valid, slvx_mode, slvx_proc_val, slvx_data,
        input  mstr_ready, clr_err,
        output fifo_full, fifo_afull, fifo_empty, fifo_count,
        output mstr_valid, mstr_mode, mstr_proc_val, mstr_data, ovf_err
    );

    modport master (
        output slvx_data_valid, slvx_mode, slvx_proc_val, slvx_data,
        output mstr_ready, clr_err,
        input  fifo_full, fifo_afull, fifo_empty, fifo_count,
        input  mstr_valid, mstr_mode, mstr_proc_val, mstr_data, ovf_err
    );
endinterface

// File: rtl/arb_fifo.sv
// First-word-fall-through FIFO carrying {mode, proc_val, data} entries from the
// arbiter to the processing master, with mode-0 discard and sticky overflow flag.
module arb_fifo #(
    parameter int DW       = 32,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic      clk,
    input  logic      rst,
    arb_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DW + 10;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          wr_try_s, wr_en_s, rd_en_s;
    logic [EW-1:0] head_s;
    logic [1:0]    mstr_mode_s;
    logic [7:0]    mstr_proc_s;
    logic [DW-1:0] mstr_data_s;

    // Handshake decode and next-state for pointers, occupancy and error flag
    always_comb begin
        wr_try_s = bus.slvx_data_valid && (bus.slvx_mode != 2'd0);
        wr_en_s  = wr_try_s && !full_q;
        rd_en_s  = !empty_q && bus.mstr_ready;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        // Flags are registered alongside the count so they always agree with it
        full_d  = (count_d == DEPTH_C);
        afull_d = (count_d >= AFULL_C);
        empty_d = (count_d == {CW{1'b0}});

        // A dropped write outranks a same-cycle clear so no overflow is lost
        if (wr_try_s && full_q) begin
            ovf_d = 1'b1;
        end else if (bus.clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset term
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_q[wr_ptr_q] <= {bus.slvx_mode, bus.slvx_proc_val, bus.slvx_data};
        end
    end

    // Head presentation, forced to zero while nothing is valid
    always_comb begin
        head_s = mem_q[rd_ptr_q];
        if (empty_q) begin
            mstr_mode_s = 2'd0;
            mstr_proc_s = 8'd0;
            mstr_data_s = {DW{1'b0}};
        end else begin
            mstr_mode_s = head_s[EW-1 -: 2];
            mstr_proc_s = head_s[DW+7 -: 8];
            mstr_data_s = head_s[DW-1:0];
        end
    end

    assign bus.fifo_full     = full_q;
    assign bus.fifo_afull    = afull_q;
    assign bus.fifo_empty    = empty_q;
    assign bus.fifo_count    = count_q;
    assign bus.mstr_valid    = !empty_q;
    assign bus.mstr_mode     = mstr_mode_s;
    assign bus.mstr_proc_val = mstr_proc_s;
    assign bus.mstr_data     = mstr_data_s;
    assign bus.ovf_err       = ovf_q;
endmodule

// File: tb/tb_arb_fifo.sv
// Bench for arb_fifo: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the FIFO.
module tb_arb_fifo;
    localparam int DW       = 32;
    localparam int DEPTH    = 16;
    localparam int AFULL_TH = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    logic [DW+9:0] q[$];
    bit            ovf_m = 1'b0;
    logic [DW+9:0] exp_head;
    int            n;

    arb_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus();

    arb_fifo #(.DW(DW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] m, input logic [7:0] p,
                         input logic [DW-1:0] d, input bit rdy, input bit clr, input bit r);
        bus.slvx_data_valid = v;
        bus.slvx_mode       = m;
        bus.slvx_proc_val   = p;
        bus.slvx_data       = d;
        bus.mstr_ready      = rdy;
        bus.clr_err         = clr;
        rst                 = r;
    endtask

    // One clock: apply the FIFO rules to the model at the edge, return after the falling edge
    task automatic tick();
        bit attempt;
        bit was_full;
        @(posedge clk);
        if (rst) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            attempt  = bus.slvx_data_valid && (bus.slvx_mode != 2'd0);
            was_full = (q.size() == DEPTH);
            if (q.size() > 0 && bus.mstr_ready) void'(q.pop_front());
            if (attempt && !was_full) q.push_back({bus.slvx_mode, bus.slvx_proc_val, bus.slvx_data});
            if (attempt && was_full) ovf_m = 1'b1;
            else if (bus.clr_err) ovf_m = 1'b0;
        end
        @(negedge clk);
        #1;
    endtask

    // Compare process: every DUT output against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            n = q.size();
            exp_head = (n != 0) ? q[0] : '0;
            chk("count", 64'(bus.fifo_count), 64'(n));
            chk("full",  64'(bus.fifo_full),  64'(n == DEPTH));
            chk("afull", 64'(bus.fifo_afull), 64'(n >= AFULL_TH));
            chk("empty", 64'(bus.fifo_empty), 64'(n == 0));
            chk("valid", 64'(bus.mstr_valid), 64'(n != 0));
            chk("mode",  64'(bus.mstr_mode),     64'(exp_head[DW+9 -: 2]));
            chk("proc",  64'(bus.mstr_proc_val), 64'(exp_head[DW+7 -: 8]));
            chk("data",  64'(bus.mstr_data),     64'(exp_head[DW-1:0]));
            chk("ovf",   64'(bus.ovf_err),       64'(ovf_m));
        end
    end

    initial begin
        drive(1'b0, 2'd0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_empty", 64'(bus.fifo_empty), 64'd1);
        chk("rst_valid", 64'(bus.mstr_valid), 64'd0);
        chk("rst_data",  64'(bus.mstr_data),  64'd0);

        // Mode-0 write is discarded
        drive(1'b1, 2'd0, 8'd0, 32'h55, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'd0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("m0_empty", 64'(bus.fifo_empty), 64'd1);
        chk("m0_valid", 64'(bus.mstr_valid), 64'd0);
        chk("m0_ovf",   64'(bus.ovf_err),    64'd0);

        // Fill with ready low
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'd1, 8'(i), 32'(i), 1'b0, 1'b0, 1'b0);
            tick();
            if (i == 12) chk("afull_13", 64'(bus.fifo_afull), 64'd0);
            if (i == 13) chk("afull_14", 64'(bus.fifo_afull), 64'd1);
            if (i == 14) chk("full_15",  64'(bus.fifo_full),  64'd0);
        end
        chk("fill_full",  64'(bus.fifo_full),  64'd1);
        chk("fill_count", 64'(bus.fifo_count), 64'd16);
        chk("fill_head",  64'(bus.mstr_data),  64'd0);

        // Write into full FIFO while popping: dropped, overflow flagged
        drive(1'b1, 2'd2, 8'd0, 32'hDEAD, 1'b1, 1'b0, 1'b0);
        tick();
        chk("ovf_count", 64'(bus.fifo_count), 64'd15);
        chk("ovf_set",   64'(bus.ovf_err),    64'd1);
        chk("ovf_head",  64'(bus.mstr_data),  64'd1);
        drive(1'b0, 2'd0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("ovf_clr", 64'(bus.ovf_err), 64'd0);

        // Drain remaining entries in order
        for (int i = 1; i < 16; i++) begin
            chk("drain_data", 64'(bus.mstr_data), 64'(i));
            drive(1'b0, 2'd0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("drain_empty", 64'(bus.fifo_empty), 64'd1);

        // Overflow and clear on the same edge: set wins
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'd3, 8'(i), 32'(i + 200), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 2'd3, 8'd0, 32'hBEEF, 1'b0, 1'b1, 1'b0);
        tick();
        chk("race_ovf", 64'(bus.ovf_err), 64'd1);

        // Reset with concurrent write discards everything
        drive(1'b1, 2'd1, 8'd7, 32'h77, 1'b1, 1'b1, 1'b1);
        tick();
        chk("mrst_count", 64'(bus.fifo_count), 64'd0);
        chk("mrst_valid", 64'(bus.mstr_valid), 64'd0);
        chk("mrst_ovf",   64'(bus.ovf_err),    64'd0);
        drive(1'b1, 2'd1, 8'd1, 32'hA5, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mrst_a5",    64'(bus.mstr_data),  64'hA5);
        chk("mrst_v",     64'(bus.mstr_valid), 64'd1);

        // Streaming: write and pop every cycle, occupancy stays at one
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 2'd2, 8'(i), 32'(100 + i), 1'b1, 1'b0, 1'b0);
            tick();
            chk("strm_count", 64'(bus.fifo_count), 64'd1);
            chk("strm_data",  64'(bus.mstr_data),  64'(100 + i));
        end

        // Randomized traffic with alternating back-pressure phases
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 9) < 7), 2'($urandom), 8'($urandom), 32'($urandom),
                  (((c / 100) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
            tick();
        end

        drive(1'b0, 2'd0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("final_empty", 64'(bus.fifo_empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/arb_fifo.md
ARB_FIFO -- requirements
Module: arb_fifo

Interface
REQ-001 SHALL have parameter DW, default 32, meaning payload data width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of entries (power of 2, >= 4).
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, meaning almost-full threshold in entries.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port slvx_data_valid  input  1  write strobe from arbiter.
REQ-007 SHALL have port slvx_mode  input  2  pixel-operation mode of the write.
REQ-008 SHALL have port slvx_proc_val  input  8  processing operand of the write.
REQ-009 SHALL have port slvx_data  input  DW  pixel data of the write.
REQ-010 SHALL have port fifo_full  output  1  back-pressure to arbiter.
REQ-011 SHALL have port fifo_afull  output  1  count >= AFULL_TH.
REQ-012 SHALL have port fifo_empty  output  1  count == 0.
REQ-013 SHALL have port fifo_count  output  $clog2(DEPTH)+1  stored entries.
REQ-014 SHALL have port mstr_valid  output  1  head entry valid to processing master.
REQ-015 SHALL have port mstr_ready  input  1  master accepts head entry.
REQ-016 SHALL have port mstr_mode  output  2  head entry mode.
REQ-017 SHALL have port mstr_proc_val  output  8  head entry operand.
REQ-018 SHALL have port mstr_data  output  DW  head entry data.
REQ-019 SHALL have port ovf_err  output  1  sticky overflow flag.
REQ-020 SHALL have port clr_err  input  1  clears ovf_err.

Function
REQ-021 Entry SHALL be {mode, proc_val, data}, 10+DW bits, stored in circular buffer with wrapping read/write pointers.
REQ-022 Write SHALL occur at a rising edge when slvx_data_valid=1, slvx_mode!=0 and fifo_full=0 (flag as registered before that edge).
REQ-023 Write with slvx_mode==0 SHALL be discarded: not stored, not counted, no ovf_err.
REQ-024 Write attempt (valid=1, mode!=0) while fifo_full=1 SHALL be dropped and set ovf_err, even if a pop occurs in the same cycle.
REQ-025 Pop SHALL occur at a rising edge when mstr_valid=1 and mstr_ready=1; pointer advances, head updates next cycle.
REQ-026 Output SHALL be first-word-fall-through: mstr_valid = !fifo_empty; mstr_mode/proc_val/data show head entry combinationally from storage.
REQ-027 Latency: write at edge N into empty FIFO SHALL give mstr_valid=1 in the cycle after edge N.
REQ-028 Simultaneous accepted write and pop SHALL leave fifo_count unchanged; write into empty with mstr_ready=1 SHALL NOT pop in same edge (nothing valid yet).
REQ-029 fifo_count SHALL be registered; fifo_full = (count==DEPTH), fifo_afull = (count>=AFULL_TH), fifo_empty = (count==0), all derived from registered count.
REQ-030 mstr_ready while mstr_valid=0 SHALL have no effect.
REQ-031 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries; order SHALL be strictly FIFO.
REQ-032 ovf_err: set on REQ-024 event; cleared by clr_err=1; set SHALL win over clear in the same cycle.
REQ-033 When mstr_valid=0, mstr_mode, mstr_proc_val, mstr_data SHALL be 0.

Reset
REQ-034 On rst=1 at an edge: pointers=0, fifo_count=0, fifo_empty=1, fifo_full=0, fifo_afull=0, mstr_valid=0, mstr outputs 0, ovf_err=0.
REQ-035 Reset SHALL override any simultaneous write, pop or clr_err; storage contents need not be cleared.
REQ-036 Reset mid-operation SHALL discard all stored entries; first write after reset SHALL be the first entry read.

Verification
REQ-037 Fill/drain: write 16 entries (mode=1, proc_val=i, data=i) with mstr_ready=0 -> fifo_afull after 14th, fifo_full after 16th, count=16; then mstr_ready=1 -> data 0..15 in order, fifo_empty after 16 pops.
REQ-038 Overflow: full FIFO, write mode=2 data=0xDEAD with mstr_ready=1 -> write dropped, ovf_err=1, count=15; clr_err pulse -> ovf_err=0.
REQ-039 Mode-0 drop: write mode=0 data=0x55 into empty FIFO -> fifo_empty stays 1, mstr_valid stays 0, ovf_err=0.
REQ-040 Streaming: continuous writes and mstr_ready=1 for 40 cycles -> count constant 1 after first write, 40 entries out in order, pointers wrap twice.
REQ-041 Reset mid-stream: 5 entries stored, rst=1 with concurrent write -> count=0, mstr_valid=0; next write data=0xA5 -> mstr_data=0xA5 one cycle later.
REQ-042 Set/clear race: overflow event and clr_err=1 same edge -> ovf_err=1.
